// File: rtl/dispatch_pkg.sv
// Shared types and defaults for the dispatch controller.
//   state_e   : dispatch FSM encoding (RUN / BR_WAIT / FLUSH)
//   TAG_W_DEF : default ROB/CDB tag width
package dispatch_pkg;

    localparam int unsigned TAG_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/dispatch_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
//   clock   : system clock
//   reset   : async active-low reset (clears count)
//   inc     : increment request for this cycle
//   count   : current count value
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Instruction dispatch sequencer between the IFQ head, decoder and the
// integer / LD-ST / MULT issue queues. Fires one instruction per cycle when
// the target queue, ROB and tag FIFO have room; stalls behind an unresolved
// branch and flushes/redirects fetch on a mispredict.
//   IFQ side   : ifq_empty, ifq_inst in; ifq_rd_en out (comb)
//   decoder    : dec_en_integer/ld_st/mult, dec_is_branch in
//   back-press : int_q_full, ldst_q_full, mult_q_full, rob_full, tag_fifo_empty
//   tag FIFO   : tag_in in; tag_rd_en out (comb)
//   dispatch   : disp_en_*, disp_inst, disp_tag out (registered)
//   CDB        : cdb_valid, cdb_tag, cdb_br_mispredict, cdb_br_target in
//   recovery   : flush, redirect_pc out (registered)
//   perf       : stall_cycles out (registered, saturating)
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int unsigned TAG_W       = TAG_W_DEF,
    parameter int unsigned FLUSH_CYC   = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ifq_empty,
    input  logic [31:0]            ifq_inst,
    output logic                   ifq_rd_en,
    input  logic                   dec_en_integer,
    input  logic                   dec_en_ld_st,
    input  logic                   dec_en_mult,
    input  logic                   dec_is_branch,
    input  logic                   int_q_full,
    input  logic                   ldst_q_full,
    input  logic                   mult_q_full,
    input  logic                   rob_full,
    input  logic                   tag_fifo_empty,
    input  logic [TAG_W-1:0]       tag_in,
    output logic                   tag_rd_en,
    output logic                   disp_en_integer,
    output logic                   disp_en_ld_st,
    output logic                   disp_en_mult,
    output logic [31:0]            disp_inst,
    output logic [TAG_W-1:0]       disp_tag,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_tag,
    input  logic                   cdb_br_mispredict,
    input  logic [31:0]            cdb_br_target,
    output logic                   flush,
    output logic [31:0]            redirect_pc,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   br_tag_q, br_tag_d;
    logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic               flush_q, flush_d;
    logic [31:0]        redirect_q, redirect_d;
    logic               en_int_q, en_ldst_q, en_mult_q;
    logic [31:0]        inst_q;
    logic [TAG_W-1:0]   tag_q;

    logic               need_q;
    logic               any_en;
    logic               head_ok;
    logic               fire;
    logic               drop;
    logic               stall_inc;
    logic               cdb_hit;

    // dispatch qualification for the current head
    always_comb begin
        need_q    = (dec_en_integer & int_q_full) |
                    (dec_en_ld_st   & ldst_q_full) |
                    (dec_en_mult    & mult_q_full);
        any_en    = dec_en_integer | dec_en_ld_st | dec_en_mult;
        head_ok   = (state_q == ST_RUN) & ~ifq_empty;
        fire      = head_ok & any_en & ~need_q & ~rob_full & ~tag_fifo_empty;
        drop      = head_ok & ~any_en;
        stall_inc = head_ok & ~fire & ~drop;
        cdb_hit   = cdb_valid & (cdb_tag == br_tag_q);
    end

    assign ifq_rd_en = fire | drop;
    assign tag_rd_en = fire;

    // next-state and recovery outputs
    always_comb begin
        state_d     = state_q;
        br_tag_d    = br_tag_q;
        flush_cnt_d = flush_cnt_q;
        flush_d     = 1'b0;
        redirect_d  = redirect_q;
        case (state_q)
            ST_RUN: begin
                if (fire && dec_is_branch) begin
                    br_tag_d = tag_in;
                    state_d  = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (cdb_hit) begin
                    if (cdb_br_mispredict) begin
                        state_d     = ST_FLUSH;
                        flush_d     = 1'b1;
                        redirect_d  = cdb_br_target;
                        flush_cnt_d = FC_W'(FLUSH_CYC - 1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            br_tag_q    <= '0;
            flush_cnt_q <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            en_int_q    <= 1'b0;
            en_ldst_q   <= 1'b0;
            en_mult_q   <= 1'b0;
            inst_q      <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            br_tag_q    <= br_tag_d;
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            en_int_q    <= fire & dec_en_integer;
            en_ldst_q   <= fire & dec_en_ld_st;
            en_mult_q   <= fire & dec_en_mult;
            if (fire) begin
                inst_q <= ifq_inst;
                tag_q  <= tag_in;
            end
        end
    end

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    assign disp_en_integer = en_int_q;
    assign disp_en_ld_st   = en_ldst_q;
    assign disp_en_mult    = en_mult_q;
    assign disp_inst       = inst_q;
    assign disp_tag        = tag_q;
    assign flush           = flush_q;
    assign redirect_pc     = redirect_q;

endmodule
